// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-word buffer between instruction memory and decode.
// Latency: 1 cycle from the ack edge to instr_valid; decode_ready=0 holds the word and blocks new fetches.
module fetch_unit #(
  parameter logic [25:0] RESET_PC = 26'h0000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [25:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        decode_ready,
  input  logic        load_pc,
  input  logic [25:0] load_pc_val,
  input  logic        halt,
  output logic [25:0] pc,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [25:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic        consume;

  assign consume = valid_q & decode_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      IDLE: state_d = halt ? HALTED : FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Redirects only apply to the word being consumed.
        if (consume) begin
          valid_d = 1'b0;
          count_d = count_q + 32'd1;
          pc_d    = load_pc ? load_pc_val : pc_q + 26'd1;
          state_d = halt ? HALTED : FETCH;
        end
      end
      HALTED: begin
        if (!halt) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reset vector table, directed corner sequences, random run against a flag-level model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [25:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        decode_ready;
  logic        load_pc;
  logic [25:0] load_pc_val;
  logic        halt;
  logic [25:0] pc;
  logic [31:0] fetch_count;

  logic        junk_en;
  logic [31:0] junk_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory returns 0x04000000 | addr unless a specific word is injected.
  assign imem_rdata = junk_en ? junk_val : (32'h04000000 | {6'd0, imem_addr});

  fetch_unit #(.RESET_PC(26'h0000000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instruction(instruction), .instr_valid(instr_valid), .decode_ready(decode_ready),
    .load_pc(load_pc), .load_pc_val(load_pc_val), .halt(halt),
    .pc(pc), .fetch_count(fetch_count)
  );

  typedef struct {
    logic        ack, rdy, lpc;
    logic [25:0] lval;
    logic        hlt;
    logic        exp_req, exp_valid, chk_instr;
    logic [31:0] exp_instr;
    logic [25:0] exp_pc;
    logic [31:0] exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic r, input logic l, input logic [25:0] v, input logic h);
    imem_ack = a; decode_ready = r; load_pc = l; load_pc_val = v; halt = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic h);
    rst_n = 1'b0;
    junk_en = 1'b0; junk_val = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 26'h0, h);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc", {6'd0, pc}, 32'h0);
    chk("rst_cnt", fetch_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req", {31'd0, imem_req}, 32'd0);
  endtask

  vec_t tbl[12];

  // Random-run model state
  logic        m_idle, m_halted, m_valid;
  logic [25:0] m_pc;
  logic [31:0] m_cnt, m_word;

  initial begin
    tbl[0]  = '{1'b0,1'b0,1'b0,26'h0, 1'b0, 1'b1,1'b0,1'b0,32'h0,        26'd0,32'd0};
    tbl[1]  = '{1'b0,1'b0,1'b1,26'h20,1'b0, 1'b1,1'b0,1'b0,32'h0,        26'd0,32'd0};
    tbl[2]  = '{1'b1,1'b0,1'b0,26'h0, 1'b0, 1'b0,1'b1,1'b1,32'h04000000, 26'd0,32'd0};
    tbl[3]  = '{1'b1,1'b0,1'b0,26'h0, 1'b0, 1'b0,1'b1,1'b1,32'h04000000, 26'd0,32'd0};
    tbl[4]  = '{1'b0,1'b1,1'b0,26'h0, 1'b0, 1'b1,1'b0,1'b0,32'h0,        26'd1,32'd1};
    tbl[5]  = '{1'b1,1'b0,1'b0,26'h0, 1'b0, 1'b0,1'b1,1'b1,32'h04000001, 26'd1,32'd1};
    tbl[6]  = '{1'b0,1'b1,1'b0,26'h0, 1'b0, 1'b1,1'b0,1'b0,32'h0,        26'd2,32'd2};
    tbl[7]  = '{1'b1,1'b0,1'b0,26'h0, 1'b0, 1'b0,1'b1,1'b1,32'h04000002, 26'd2,32'd2};
    tbl[8]  = '{1'b0,1'b1,1'b0,26'h0, 1'b0, 1'b1,1'b0,1'b0,32'h0,        26'd3,32'd3};
    tbl[9]  = '{1'b1,1'b0,1'b0,26'h0, 1'b0, 1'b0,1'b1,1'b1,32'h04000003, 26'd3,32'd3};
    tbl[10] = '{1'b0,1'b1,1'b0,26'h0, 1'b0, 1'b1,1'b0,1'b0,32'h0,        26'd4,32'd4};
    tbl[11] = '{1'b0,1'b1,1'b0,26'h0, 1'b0, 1'b1,1'b0,1'b0,32'h0,        26'd4,32'd4};

    // In-order fetch from reset
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ack, tbl[i].rdy, tbl[i].lpc, tbl[i].lval, tbl[i].hlt);
      tick();
      chk($sformatf("tbl%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].exp_req});
      chk($sformatf("tbl%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d_pc", i), {6'd0, pc}, {6'd0, tbl[i].exp_pc});
      chk($sformatf("tbl%0d_addr", i), {6'd0, imem_addr}, {6'd0, tbl[i].exp_pc});
      chk($sformatf("tbl%0d_cnt", i), fetch_count, tbl[i].exp_cnt);
      if (tbl[i].chk_instr) chk($sformatf("tbl%0d_instr", i), instruction, tbl[i].exp_instr);
    end

    // Redirect on consume
    do_reset(1'b0);
    tick();
    junk_en = 1'b1; junk_val = 32'h18000010;
    drive(1'b1, 1'b0, 1'b0, 26'h0, 1'b0);
    tick();
    junk_en = 1'b0;
    chk("redir_held", instruction, 32'h18000010);
    drive(1'b0, 1'b1, 1'b1, 26'h10, 1'b0);
    tick();
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    chk("redir_addr", {6'd0, imem_addr}, 32'h10);
    chk("redir_cnt", fetch_count, 32'd1);

    // PC wrap at the top of the address space
    drive(1'b1, 1'b0, 1'b0, 26'h0, 1'b0); tick();
    chk("wrap_word", instruction, 32'h04000010);
    drive(1'b0, 1'b1, 1'b1, 26'h3FFFFFF, 1'b0); tick();
    chk("wrap_top_addr", {6'd0, imem_addr}, 32'h03FFFFFF);
    drive(1'b1, 1'b0, 1'b0, 26'h0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 26'h15, 1'b0); tick();
    chk("wrap_addr", {6'd0, imem_addr}, 32'h0);
    chk("wrap_req", {31'd0, imem_req}, 32'd1);
    chk("wrap_cnt", fetch_count, 32'd3);

    // Halt at consume of the word at pc=5
    drive(1'b1, 1'b0, 1'b0, 26'h0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 26'h5, 1'b0); tick();
    chk("halt_pre_addr", {6'd0, imem_addr}, 32'h5);
    drive(1'b1, 1'b0, 1'b0, 26'h0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 26'h0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("halted%0d_req", i), {31'd0, imem_req}, 32'd0);
      chk($sformatf("halted%0d_pc", i), {6'd0, pc}, 32'h6);
      drive(1'b1, 1'b1, 1'b1, 26'h33, 1'b1);
      if (i == 2) drive(1'b0, 1'b0, 1'b0, 26'h0, 1'b0);
      tick();
    end
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", {6'd0, imem_addr}, 32'h6);

    // Stall in HOLD with stray acks
    drive(1'b1, 1'b0, 1'b0, 26'h0, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(i[0], 1'b0, 1'b1, 26'h2A, 1'b0);
      tick();
      chk($sformatf("stall%0d_instr", i), instruction, 32'h04000006);
      chk($sformatf("stall%0d_valid", i), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("stall%0d_req", i), {31'd0, imem_req}, 32'd0);
      chk($sformatf("stall%0d_pc", i), {6'd0, pc}, 32'h6);
    end

    // Asynchronous reset while holding a word
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_pc", {6'd0, pc}, 32'h0);
    chk("arst_cnt", fetch_count, 32'h0);

    // Halt held through reset release: IDLE must go to HALTED
    do_reset(1'b1);
    tick(); tick();
    chk("idle_halt_req", {31'd0, imem_req}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 26'h0, 1'b0); tick();
    chk("idle_resume_req", {31'd0, imem_req}, 32'd1);

    // Random run against the model
    do_reset(1'b0);
    m_idle = 1'b1; m_halted = 1'b0; m_valid = 1'b0;
    m_pc = 26'h0; m_cnt = 32'h0; m_word = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      logic a, r, l, h;
      logic [25:0] v;
      a = 1'($urandom); r = 1'($urandom); l = 1'($urandom_range(0, 3) == 0);
      v = 26'($urandom); h = ($urandom_range(0, 7) == 0);
      junk_en = !imem_req; junk_val = $urandom;
      drive(a, r, l, v, h);
      tick();
      if (m_idle) begin
        m_idle = 1'b0; m_halted = h;
      end else if (m_halted) begin
        if (!h) m_halted = 1'b0;
      end else if (m_valid) begin
        if (r) begin
          m_valid = 1'b0; m_cnt = m_cnt + 1;
          m_pc = l ? v : m_pc + 26'd1;
          m_halted = h;
        end
      end else if (a) begin
        m_valid = 1'b1; m_word = 32'h04000000 | {6'd0, m_pc};
      end
      chk("rnd_req", {31'd0, imem_req}, {31'd0, !m_idle && !m_halted && !m_valid});
      chk("rnd_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      chk("rnd_pc", {6'd0, pc}, {6'd0, m_pc});
      chk("rnd_addr", {6'd0, imem_addr}, {6'd0, m_pc});
      chk("rnd_cnt", fetch_count, m_cnt);
      if (m_valid) chk("rnd_instr", instruction, m_word);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
